// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: parametrised N:1 registered multiplexer with a manual mode and
// a scan mode.
//
// In manual mode, sel chooses the channel. In scan mode, an internal sequencer
// stays HOLD cycles on each channel and skips channels that skip_mask excludes.
// The output register holds the data, a valid flag and the channel tag, so dout
// and cur_ch always describe the same channel.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   din        packed channel data, channel k at din[k*WIDTH +: WIDTH]
//   sel        manual channel select
//   mode       0 = manual, 1 = scan
//   en         block enable; low freezes state, drops dout_valid and wrap
//   skip_mask  bit k = 1 excludes channel k from the scan
//   dout       registered selected data
//   dout_valid dout holds data of a live channel
//   cur_ch     channel index dout was taken from
//   wrap       one-cycle pulse when the scan steps from a higher to a lower index
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | no enabled edge since reset; scan entry searches from ch0
// MAN   | manual select, hold counter parked at 0
// SCAN  | sequencer dwelling on cur_ch, hold counter running
module mux_nx1_scan #(
    parameter int WIDTH = 4,
    parameter int SEL_W = 2,
    parameter int HOLD  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [(2**SEL_W)*WIDTH-1:0] din,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       mode,
    input  logic                       en,
    input  logic [(2**SEL_W)-1:0]      skip_mask,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic [SEL_W-1:0]           cur_ch,
    output logic                       wrap
);

    localparam int CH    = 2**SEL_W;
    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAN  = 2'd1;
    localparam logic [1:0] SCAN = 2'd2;

    logic [1:0]       state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic [SEL_W-1:0] nch, adv_ch, first_ch;
    logic [WIDTH-1:0] dsel;
    logic             all_masked;
    logic             load, nxt_valid, nxt_wrap;

    // Candidate channels. adv_ch is the first unmasked index after cur_ch,
    // searching upward modulo CH. If no other channel is live, it falls back to
    // cur_ch itself. first_ch is the lowest unmasked index, used on scan entry
    // from IDLE. The loops run downward so the nearest match is written last.
    always_comb begin
        all_masked = &skip_mask;
        adv_ch     = cur_ch;
        for (int i = CH - 1; i >= 1; i--) begin
            if (!skip_mask[cur_ch + SEL_W'(i)]) begin
                adv_ch = cur_ch + SEL_W'(i);
            end
        end
        first_ch = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (!skip_mask[i]) begin
                first_ch = SEL_W'(i);
            end
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nch       = cur_ch;
        load      = 1'b0;
        nxt_valid = 1'b0;
        nxt_wrap  = 1'b0;
        if (!mode) begin
            // The mode input decides the behaviour of this edge, so a switch
            // from SCAN to manual selects sel immediately.
            nxt_state = MAN;
            nxt_cnt   = '0;
            nch       = sel;
            load      = 1'b1;
            nxt_valid = 1'b1;
        end else begin
            nxt_state = SCAN;
            nxt_cnt   = '0;
            if (all_masked) begin
                // Nothing is live: freeze the channel and the data.
                nch = cur_ch;
            end else if (state == IDLE) begin
                nch       = first_ch;
                load      = 1'b1;
                nxt_valid = 1'b1;
            end else if (skip_mask[cur_ch] || cnt == CNT_LAST) begin
                // The dwell has ended, or the current channel was masked during
                // the dwell. Coming from MAN, the counter is already 0, so this
                // is the normal scan rule.
                nch       = adv_ch;
                load      = 1'b1;
                nxt_valid = 1'b1;
                nxt_wrap  = (adv_ch < cur_ch);
            end else begin
                nch       = cur_ch;
                nxt_cnt   = cnt + CNT_W'(1);
                load      = 1'b1;
                nxt_valid = 1'b1;
            end
        end
    end

    always_comb begin
        dsel = '0;
        for (int k = 0; k < CH; k++) begin
            if (nch == SEL_W'(k)) begin
                dsel = din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_ch     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            wrap       <= 1'b0;
        end else if (en) begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            cur_ch     <= nch;
            if (load) begin
                dout <= dsel;
            end
            dout_valid <= nxt_valid;
            wrap       <= nxt_wrap;
        end else begin
            dout_valid <= 1'b0;
            wrap       <= 1'b0;
        end
    end

endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
- Parametrised N:1 registered multiplexer; successor to the combinational 4:1 mux built from 2:1 stages.
- Two modes:
  - Manual: external select.
  - Scan: internal sequencer steps through channels, dwelling HOLD cycles on each and skipping masked channels.
- Sits between parallel sensor/data lanes and a single serial consumer; output is registered with a valid flag and a channel tag.

Parameters:
- WIDTH, 4, bit width of each channel.
- SEL_W, 2, select width; channel count CH = 2**SEL_W.
- HOLD, 4, dwell cycles per channel in scan mode (must be ≥ 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  CH*WIDTH  packed channel data; channel k occupies din[k*WIDTH +: WIDTH].
- sel  input  SEL_W  manual channel select.
- mode  input  1  0 = manual, 1 = scan.
- en  input  1  block enable; low freezes all state.
- skip_mask  input  CH  bit k = 1 excludes channel k from scan (ignored in manual mode).
- dout  output  WIDTH  registered selected data.
- dout_valid  output  1  dout holds data of a live channel.
- cur_ch  output  SEL_W  channel index dout was taken from.
- wrap  output  1  one-cycle pulse when scan wraps from a higher to a lower index.

Behaviour:
- Reset (async, immediate): dout=0, dout_valid=0, cur_ch=0, wrap=0, hold counter=0, state=IDLE.
- States:
  - IDLE: first enabled edge after reset.
  - MAN: manual mode.
  - SCAN: scan mode.
- State transitions, on enabled edges only:
  - IDLE → MAN if mode=0, IDLE → SCAN if mode=1.
  - MAN → SCAN when mode=1.
  - SCAN → MAN when mode=0.
- All updates happen only on edges with en=1. With en=0, every register holds except dout_valid, which goes 0 and wrap, which goes 0.
- Single rule for all states: a combinational next-channel nch is computed; on the edge, cur_ch <= nch and dout <= din slice of nch. Latency from din/sel to dout is 1 cycle, and dout and cur_ch are always consistent.
- MAN:
  - nch = sel.
  - dout_valid=1 every enabled cycle.
  - Hold counter forced to 0.
  - wrap=0.
- SCAN:
  - Hold counter counts 0..HOLD-1 on the current channel.
  - While the counter < HOLD-1 and cur_ch is unmasked: nch = cur_ch, counter increments.
  - When the counter = HOLD-1, or cur_ch is masked (including a mask set mid-dwell): nch = first unmasked index after cur_ch, searching upward modulo CH. The counter is cleared.
  - If the only unmasked channel is cur_ch, nch = cur_ch; the counter still clears and wrap is not pulsed.
  - wrap=1 for exactly the cycle where nch < cur_ch.
  - All channels masked: cur_ch and dout hold, dout_valid=0, counter held at 0, wrap=0. When any bit clears, the scan resumes from the next unmasked index after cur_ch.
  - dout_valid=1 whenever a live channel is selected.
- Mode switches:
  - IDLE → SCAN: the first enabled edge selects channel 0 if unmasked, else the next unmasked channel.
  - MAN → SCAN: the scan starts at the current cur_ch with the counter cleared; if cur_ch is masked, it advances on the first scan cycle.
  - SCAN → MAN: takes effect on the same edge that mode=0 is sampled; nch = sel.
- HOLD=1: the channel advances every enabled cycle.
- Reset asserted mid-scan returns everything to reset values immediately; the first enabled edge after release behaves as IDLE.
- din changes during a dwell: dout follows live data of cur_ch with 1-cycle latency (no sampling at channel entry).

Test Plan (WIDTH=4, SEL_W=2, HOLD=3, din={4'hD,4'hC,4'hB,4'hA} ch3..ch0):
- Manual sweep: mode=0, en=1, sel=0,1,2,3 one cycle each → dout=A,B,C,D one cycle later, cur_ch tracks sel, dout_valid=1; sel=3→0 gives wrap=0.
- Scan, no mask: mode=1 from reset → dout=A×3, B×3, C×3, D×3, A…; wrap=1 only on the cycle dout returns to A.
- Scan with skip_mask=4'b0101 → dout cycles B×3, D×3, B…; wrap on each D→B step. Setting bit1 mid-dwell on B → next edge jumps to D.
- All masked: skip_mask=4'hF while scanning on C → dout holds C, dout_valid=0, wrap=0. Clearing bit0 → next edge dout=A, dout_valid=1, wrap=1.
- Enable and mode: en=0 for 5 cycles mid-dwell → cur_ch/dout/counter frozen, dout_valid=0, dwell resumes with remaining count. Then mode=0 with sel=2 → dout=C on the next edge.
- Async reset mid-scan (asserted between edges) → dout=0, dout_valid=0, cur_ch=0 immediately without a clock edge. After release with mode=1 → first edge dout=A.
